// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer
// Run-time display-mode controller for the VGA timing chain. Mode change
// requests arrive over a valid/ready handshake and are held until the end of
// the current frame. The sequencer then blanks the video, holds the sync
// counters in reset, loads the new timing parameter set and releases the
// counters again.
//
// Optional feature: define VGA_MODE_XGA_EN to add mode 4'b0111 (1024x768).
// Without it, 4'b0111 is rejected like any other undefined code.
//
// Ports
//   clk             system/pixel clock, rising edge
//   rst             asynchronous reset, active low
//   mode_req        requested mode code
//   mode_req_valid  request valid
//   mode_req_ready  sequencer can accept a request
//   frame_end       one-cycle pulse from the vertical counter at frame wrap
//   h_* / v_*       ten 12-bit timing parameters for the sync counters
//   timing_rst_n    active-low reset to the sync counters
//   blank           forces the video output to black
//   active_mode     mode currently loaded
//   mode_done       pulse: change completed or same-mode request accepted
//   mode_err        pulse: unsupported mode requested
//
// State     | meaning
// ----------+----------------------------------------------------------
// RUN       | normal display, requests accepted
// WAIT_EOF  | change pending, waiting for frame_end
// BLANK     | counters held in reset for HOLD_CYCLES cycles
// LOAD      | parameter set and active_mode loaded on the leaving edge
// SETTLE    | one extra reset cycle with the new parameters in place

module vga_mode_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode_req,
  input  logic        mode_req_valid,
  output logic        mode_req_ready,
  input  logic        frame_end,
  output logic [11:0] h_visible,
  output logic [11:0] h_front,
  output logic [11:0] h_sync,
  output logic [11:0] h_back,
  output logic [11:0] h_total,
  output logic [11:0] v_visible,
  output logic [11:0] v_front,
  output logic [11:0] v_sync,
  output logic [11:0] v_back,
  output logic [11:0] v_total,
  output logic        timing_rst_n,
  output logic        blank,
  output logic [3:0]  active_mode,
  output logic        mode_done,
  output logic        mode_err
);

  localparam logic [3:0] MODE_VGA  = 4'b0001;
  localparam logic [3:0] MODE_SVGA = 4'b0101;
  localparam logic [3:0] MODE_XGA  = 4'b0111;

  // The counter is loaded with HOLD_CYCLES-1 so BLANK lasts exactly
  // HOLD_CYCLES cycles including the cycle in which it reaches zero.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef struct packed {
    logic [11:0] h_visible;
    logic [11:0] h_front;
    logic [11:0] h_sync;
    logic [11:0] h_back;
    logic [11:0] h_total;
    logic [11:0] v_visible;
    logic [11:0] v_front;
    logic [11:0] v_sync;
    logic [11:0] v_back;
    logic [11:0] v_total;
  } timing_t;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_WAIT_EOF = 3'd1,
    ST_BLANK    = 3'd2,
    ST_LOAD     = 3'd3,
    ST_SETTLE   = 3'd4
  } state_t;

  function automatic logic mode_supported(input logic [3:0] m);
    logic ok;
    ok = 1'b0;
    case (m)
      MODE_VGA:  ok = 1'b1;
      MODE_SVGA: ok = 1'b1;
`ifdef VGA_MODE_XGA_EN
      MODE_XGA:  ok = 1'b1;
`endif
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Unsupported codes never reach LOAD, so the default arm is only a
  // well-defined fallback.
  function automatic timing_t mode_timing(input logic [3:0] m);
    timing_t t;
    case (m)
      MODE_SVGA: t = '{12'd800,  12'd56, 12'd120, 12'd64,  12'd1040,
                       12'd600,  12'd37, 12'd6,   12'd23,  12'd666};
`ifdef VGA_MODE_XGA_EN
      MODE_XGA:  t = '{12'd1024, 12'd24, 12'd136, 12'd160, 12'd1344,
                       12'd768,  12'd3,  12'd6,   12'd29,  12'd806};
`endif
      default:   t = '{12'd640,  12'd16, 12'd96,  12'd48,  12'd800,
                       12'd480,  12'd10, 12'd2,   12'd33,  12'd525};
    endcase
    return t;
  endfunction

  state_t     state;
  state_t     next_state;
  logic [7:0] hold_cnt;
  logic [3:0] pending_mode;
  timing_t    timing_q;

  logic       accept;
  logic       req_ok;
  logic       req_same;
  logic       ready_d;
  logic       timing_rst_n_d;
  logic       blank_d;
  logic       done_d;
  logic       err_d;

  // mode_req_ready is registered and only ever high in RUN, so it gates the
  // first cycle after reset release as well.
  assign accept   = (state == ST_RUN) && mode_req_ready && mode_req_valid;
  assign req_ok   = mode_supported(mode_req);
  assign req_same = (mode_req == active_mode);

  // State register, working registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_RUN;
      hold_cnt       <= 8'd0;
      pending_mode   <= MODE_VGA;
      timing_q       <= mode_timing(MODE_VGA);
      active_mode    <= MODE_VGA;
      mode_req_ready <= 1'b0;
      timing_rst_n   <= 1'b0;
      blank          <= 1'b1;
      mode_done      <= 1'b0;
      mode_err       <= 1'b0;
    end else begin
      state          <= next_state;
      mode_req_ready <= ready_d;
      timing_rst_n   <= timing_rst_n_d;
      blank          <= blank_d;
      mode_done      <= done_d;
      mode_err       <= err_d;

      if (accept && req_ok && !req_same) begin
        pending_mode <= mode_req;
      end

      if ((state == ST_WAIT_EOF) && frame_end) begin
        hold_cnt <= HOLD_LOAD;
      end else if ((state == ST_BLANK) && (hold_cnt != 8'd0)) begin
        hold_cnt <= hold_cnt - 8'd1;
      end

      if (state == ST_LOAD) begin
        timing_q    <= mode_timing(pending_mode);
        active_mode <= pending_mode;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        // frame_end is deliberately ignored here, including when it
        // coincides with the accepting handshake.
        if (accept && req_ok && !req_same) begin
          next_state = ST_WAIT_EOF;
        end
      end
      ST_WAIT_EOF: begin
        if (frame_end) begin
          next_state = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (hold_cnt == 8'd0) begin
          next_state = ST_LOAD;
        end
      end
      ST_LOAD:   next_state = ST_SETTLE;
      ST_SETTLE: next_state = ST_RUN;
      default:   next_state = ST_RUN;
    endcase
  end

  // Output logic: next values for the registered outputs, derived from the
  // state being entered so each output is aligned with its state.
  always_comb begin
    ready_d        = (next_state == ST_RUN);
    timing_rst_n_d = (next_state == ST_RUN) || (next_state == ST_WAIT_EOF);
    blank_d        = !timing_rst_n_d;
    done_d         = (state == ST_SETTLE) || (accept && req_ok && req_same);
    err_d          = accept && !req_ok;
  end

  assign h_visible = timing_q.h_visible;
  assign h_front   = timing_q.h_front;
  assign h_sync    = timing_q.h_sync;
  assign h_back    = timing_q.h_back;
  assign h_total   = timing_q.h_total;
  assign v_visible = timing_q.v_visible;
  assign v_front   = timing_q.v_front;
  assign v_sync    = timing_q.v_sync;
  assign v_back    = timing_q.v_back;
  assign v_total   = timing_q.v_total;

endmodule
